// File: rtl/write_master.sv
// Avalon-MM burst write master draining a show-ahead pixel FIFO into memory.
// Define WM_PARTIAL_BURST_EN to write a short tail as one burst instead of single-beat bursts.
module write_master #(
  parameter int unsigned BURST_MAX = 8,
  parameter int unsigned USEDW_W   = 9
) (
  input  logic               iClk,
  input  logic               iRst,
  input  logic               Start,
  input  logic [31:0]        Length,
  input  logic [31:0]        WM_startaddress,
  output logic               WM_done,
  input  logic [USEDW_W-1:0] FF_pixel_usedw,
  input  logic [31:0]        FF_pixel_q,
  output logic               FF_pixel_readrequest,
  output logic               oWM_write,
  output logic [31:0]        oWM_writeaddress,
  output logic [31:0]        oWM_writedata,
  output logic [3:0]         oWM_burstcount,
  output logic [3:0]         oWM_byteenable,
  input  logic               iWM_waitrequest
);

  localparam logic [3:0] BurstMax = 4'(BURST_MAX);

  typedef enum logic [1:0] {StIdle, StWaitData, StBurst, StDone} state_e;

  state_e      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] remaining_q, remaining_d;
  logic [3:0]  burst_len_q, burst_len_d;
  logic [3:0]  beat_cnt_q, beat_cnt_d;
  logic [3:0]  beats;
  logic        in_burst;

  // Length of the next burst; the tail policy is the configurable part.
  always_comb begin
    if (remaining_q >= 32'(BURST_MAX)) begin
      beats = BurstMax;
    end else begin
`ifdef WM_PARTIAL_BURST_EN
      beats = remaining_q[3:0];
`else
      beats = 4'd1;
`endif
    end
  end

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      state_q     <= StIdle;
      addr_q      <= '0;
      remaining_q <= '0;
      burst_len_q <= '0;
      beat_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      remaining_q <= remaining_d;
      burst_len_q <= burst_len_d;
      beat_cnt_q  <= beat_cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    remaining_d = remaining_q;
    burst_len_d = burst_len_q;
    beat_cnt_d  = beat_cnt_q;
    unique case (state_q)
      StIdle, StDone: begin
        if (Start) begin
          addr_d      = WM_startaddress;
          remaining_d = Length;
          state_d     = (Length == 32'd0) ? StDone : StWaitData;
        end
      end
      StWaitData: begin
        // Whole burst must already be in the FIFO so write never drops mid-burst.
        if (32'(FF_pixel_usedw) >= 32'(beats)) begin
          burst_len_d = beats;
          beat_cnt_d  = beats;
          state_d     = StBurst;
        end
      end
      StBurst: begin
        if (!iWM_waitrequest) begin
          beat_cnt_d  = beat_cnt_q - 4'd1;
          remaining_d = remaining_q - 32'd1;
          if (beat_cnt_q == 4'd1) begin
            addr_d  = addr_q + {26'd0, burst_len_q, 2'b00};
            state_d = (remaining_q == 32'd1) ? StDone : StWaitData;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign in_burst             = (state_q == StBurst);
  assign oWM_write            = in_burst;
  assign oWM_writeaddress     = in_burst ? addr_q : '0;
  assign oWM_burstcount       = in_burst ? burst_len_q : '0;
  assign oWM_writedata        = in_burst ? FF_pixel_q : '0;
  assign FF_pixel_readrequest = in_burst & ~iWM_waitrequest;
  assign oWM_byteenable       = 4'hF;
  assign WM_done              = (state_q == StDone);

endmodule

// File: tb/tb_write_master.sv
// Scoreboard bench for write_master: a FIFO model feeds words, expected beats are queued at start.
module tb_write_master;

  localparam int BurstMax = 8;
  localparam int UsedwW   = 9;

  logic              iClk = 1'b0;
  logic              iRst;
  logic              Start;
  logic [31:0]       Length;
  logic [31:0]       WM_startaddress;
  logic              WM_done;
  logic [UsedwW-1:0] FF_pixel_usedw;
  logic [31:0]       FF_pixel_q;
  logic              FF_pixel_readrequest;
  logic              oWM_write;
  logic [31:0]       oWM_writeaddress;
  logic [31:0]       oWM_writedata;
  logic [3:0]        oWM_burstcount;
  logic [3:0]        oWM_byteenable;
  logic              iWM_waitrequest;

  write_master #(
    .BURST_MAX(BurstMax),
    .USEDW_W  (UsedwW)
  ) dut (
    .iClk                (iClk),
    .iRst                (iRst),
    .Start               (Start),
    .Length              (Length),
    .WM_startaddress     (WM_startaddress),
    .WM_done             (WM_done),
    .FF_pixel_usedw      (FF_pixel_usedw),
    .FF_pixel_q          (FF_pixel_q),
    .FF_pixel_readrequest(FF_pixel_readrequest),
    .oWM_write           (oWM_write),
    .oWM_writeaddress    (oWM_writeaddress),
    .oWM_writedata       (oWM_writedata),
    .oWM_burstcount      (oWM_burstcount),
    .oWM_byteenable      (oWM_byteenable),
    .iWM_waitrequest     (iWM_waitrequest)
  );

  always #5 iClk = ~iClk;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  bc;
  } beat_t;

  beat_t       exp_q[$];
  logic [31:0] fifo[$];
  logic [31:0] dq[$];
  int unsigned usedw_cap = 511;
  int          n_checks = 0;
  int          n_errors = 0;
  int          beats_acc = 0;
  int          wr_cycles = 0;
  logic        done_due = 1'b0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic refresh();
    int unsigned lvl;
    lvl = fifo.size();
    if (lvl > usedw_cap) lvl = usedw_cap;
    FF_pixel_usedw = lvl[UsedwW-1:0];
    FF_pixel_q     = (fifo.size() != 0) ? fifo[0] : 32'hDEAD_0000;
  endtask

  // Monitor: sample mid-cycle, compare beats against the scoreboard, pop FIFO after the edge.
  initial begin
    logic        acc;
    logic [31:0] dummy;
    refresh();
    forever begin
      @(negedge iClk);
      refresh();
      if (done_due) begin
        check("done_after_last", 64'(WM_done), 64'd1);
        done_due = 1'b0;
      end
      acc = oWM_write && !iWM_waitrequest;
      if (oWM_write) begin
        wr_cycles++;
        check("rdreq", 64'(FF_pixel_readrequest), 64'(acc));
        check("sb_nonempty", 64'(exp_q.size() != 0), 64'd1);
        if (exp_q.size() != 0) begin
          check("addr", 64'(oWM_writeaddress), 64'(exp_q[0].addr));
          check("data", 64'(oWM_writedata), 64'(exp_q[0].data));
          check("burstcount", 64'(oWM_burstcount), 64'(exp_q[0].bc));
          if (acc) begin
            dummy = exp_q.pop_front().data;
            beats_acc++;
            if (exp_q.size() == 0) done_due = 1'b1;
          end
        end
      end else begin
        check("idle_outs", {oWM_writeaddress, 27'd0, oWM_burstcount, FF_pixel_readrequest},
              64'd0);
      end
      check("byteenable", 64'(oWM_byteenable), 64'hF);
      @(posedge iClk);
      #1;
      if (acc && fifo.size() != 0) dummy = fifo.pop_front();
      refresh();
    end
  end

  task automatic tick();
    @(posedge iClk);
    #1;
  endtask

  task automatic load(input int n);
    logic [31:0] w;
    for (int i = 0; i < n; i++) begin
      w = $urandom;
      fifo.push_back(w);
      dq.push_back(w);
    end
  endtask

  task automatic model(input logic [31:0] a0, input int len);
    logic [31:0] a;
    int          rem;
    int          b;
    beat_t       e;
    a   = a0;
    rem = len;
    while (rem > 0) begin
      if (rem >= BurstMax) b = BurstMax;
      else begin
`ifdef WM_PARTIAL_BURST_EN
        b = rem;
`else
        b = 1;
`endif
      end
      for (int i = 0; i < b; i++) begin
        e.addr = a;
        e.data = dq.pop_front();
        e.bc   = 4'(b);
        exp_q.push_back(e);
      end
      a   = a + 32'(4 * b);
      rem = rem - b;
    end
  endtask

  task automatic start(input logic [31:0] a, input int len);
    Start           = 1'b1;
    WM_startaddress = a;
    Length          = 32'(len);
    tick();
    Start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int k;
    k = 0;
    while (!WM_done && k < budget) begin
      @(negedge iClk);
      k++;
    end
    check("done", 64'(WM_done), 64'd1);
    check("sb_empty", 64'(exp_q.size()), 64'd0);
    tick();
  endtask

  initial begin
    int b0;
    int w0;
    int k;
    iRst            = 1'b1;
    Start           = 1'b0;
    Length          = '0;
    WM_startaddress = '0;
    iWM_waitrequest = 1'b0;
    #1;
    check("rst_write", 64'(oWM_write), 64'd0);
    check("rst_done", 64'(WM_done), 64'd0);
    check("rst_rdreq", 64'(FF_pixel_readrequest), 64'd0);
    check("rst_addr", 64'(oWM_writeaddress), 64'd0);
    check("rst_bc", 64'(oWM_burstcount), 64'd0);
    check("rst_be", 64'(oWM_byteenable), 64'hF);
    repeat (2) @(posedge iClk);
    #1;
    iRst = 1'b0;
    tick();

    // Zero length: straight to DONE, no writes.
    w0 = wr_cycles;
    start(32'h100, 0);
    check("len0_done", 64'(WM_done), 64'd1);
    repeat (3) tick();
    check("len0_no_write", 64'(wr_cycles - w0), 64'd0);

    // Two full bursts.
    load(16);
    model(32'h1000, 16);
    start(32'h1000, 16);
    wait_done(200);

    // Tail handling.
    load(11);
    model(32'h2000, 11);
    start(32'h2000, 11);
    wait_done(200);

    // Starved FIFO holds off the burst.
    usedw_cap = 5;
    load(8);
    model(32'h3000, 8);
    w0 = wr_cycles;
    start(32'h3000, 8);
    repeat (20) begin
      @(negedge iClk);
      check("starved_no_write", 64'(oWM_write), 64'd0);
    end
    tick();
    usedw_cap = 511;
    wait_done(100);
    check("burst_cycles", 64'(wr_cycles - w0), 64'd8);

    // Slave stall on the 4th beat.
    load(8);
    model(32'h5000, 8);
    b0 = beats_acc;
    w0 = wr_cycles;
    start(32'h5000, 8);
    k = 0;
    while (beats_acc != b0 + 3 && k < 100) begin
      tick();
      k++;
    end
    check("reach_beat4", 64'(beats_acc - b0), 64'd3);
    iWM_waitrequest = 1'b1;
    repeat (3) tick();
    iWM_waitrequest = 1'b0;
    wait_done(100);
    check("pops", 64'(beats_acc - b0), 64'd8);
    check("stall_write_cycles", 64'(wr_cycles - w0), 64'd11);
    check("fifo_drained", 64'(fifo.size()), 64'd0);

    // Start pulse mid-burst is ignored.
    load(8);
    model(32'h6000, 8);
    start(32'h6000, 8);
    k = 0;
    while (!oWM_write && k < 100) begin
      tick();
      k++;
    end
    check("saw_write", 64'(oWM_write), 64'd1);
    Start           = 1'b1;
    Length          = 32'd3;
    WM_startaddress = 32'h9000;
    tick();
    Start = 1'b0;
    wait_done(100);
    repeat (4) tick();
    check("ignored_start_done", 64'(WM_done), 64'd1);

    // Address wrap-around.
    load(16);
    model(32'hFFFF_FFF0, 16);
    start(32'hFFFF_FFF0, 16);
    wait_done(200);

    // Asynchronous reset mid-burst.
    load(16);
    model(32'h7000, 16);
    b0 = beats_acc;
    start(32'h7000, 16);
    k = 0;
    while (beats_acc < b0 + 3 && k < 100) begin
      tick();
      k++;
    end
    check("reach_mid_burst", 64'(oWM_write), 64'd1);
    iRst = 1'b1;
    #1;
    check("arst_write", 64'(oWM_write), 64'd0);
    check("arst_done", 64'(WM_done), 64'd0);
    check("arst_rdreq", 64'(FF_pixel_readrequest), 64'd0);
    check("arst_addr", 64'(oWM_writeaddress), 64'd0);
    check("arst_bc", 64'(oWM_burstcount), 64'd0);
    check("arst_wdata", 64'(oWM_writedata), 64'd0);
    exp_q.delete();
    fifo.delete();
    dq.delete();
    tick();
    iRst = 1'b0;
    load(8);
    dq.delete();
    repeat (5) begin
      @(negedge iClk);
      check("post_rst_idle_write", 64'(oWM_write), 64'd0);
      check("post_rst_idle_done", 64'(WM_done), 64'd0);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
